// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: MIPS 5-stage control unit.
// Decodes op/funct in ID, carries the control bundle through ID/EX, EX/MEM
// and MEM/WB, and generates stall/bubble (and optionally forwarding) controls.
// Optional feature macro: FORWARD_EN (adds ForwardA_E/ForwardB_E and relaxes
// stalls to load-use and branch-operand hazards only).

module pipelined_control_unit #(
    parameter int ALUCTRL_W = 3,
    parameter int REG_AW    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic [REG_AW-1:0]    rs_D,
    input  logic [REG_AW-1:0]    rt_D,
    input  logic [REG_AW-1:0]    rd_D,
    output logic [1:0]           Branch_D,
    output logic                 Jump_D,
    output logic [ALUCTRL_W-1:0] AluControl_E,
    output logic                 AluSrc_E,
    output logic [REG_AW-1:0]    WriteReg_E,
    output logic                 MemWrite_M,
    output logic                 RegWrite_M,
    output logic                 MemtoReg_M,
    output logic [REG_AW-1:0]    WriteReg_M,
    output logic                 RegWrite_W,
    output logic                 MemtoReg_W,
    output logic [REG_AW-1:0]    WriteReg_W,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushE
`ifdef FORWARD_EN
    ,
    output logic [1:0]           ForwardA_E,
    output logic [1:0]           ForwardB_E
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b110);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b111);

    // decoded ID bundle
    logic                 dec_valid;
    logic                 dec_reg_write;
    logic                 dec_reg_dst;
    logic                 dec_alu_src;
    logic                 dec_mem_to_reg;
    logic                 dec_mem_write;
    logic [ALUCTRL_W-1:0] dec_alu_ctrl;
    logic [REG_AW-1:0]    dec_write_reg;
    logic                 use_rs;
    logic                 use_rt;

    // ID/EX
    logic                 reg_write_e_q,  reg_write_e_d;
    logic                 mem_to_reg_e_q, mem_to_reg_e_d;
    logic                 mem_write_e_q,  mem_write_e_d;
    logic                 alu_src_e_q,    alu_src_e_d;
    logic [ALUCTRL_W-1:0] alu_ctrl_e_q,   alu_ctrl_e_d;
    logic [REG_AW-1:0]    write_reg_e_q,  write_reg_e_d;
`ifdef FORWARD_EN
    logic [REG_AW-1:0]    rs_e_q,         rs_e_d;
    logic [REG_AW-1:0]    rt_e_q,         rt_e_d;
`endif

    // EX/MEM
    logic                 reg_write_m_q,  reg_write_m_d;
    logic                 mem_to_reg_m_q, mem_to_reg_m_d;
    logic                 mem_write_m_q,  mem_write_m_d;
    logic [REG_AW-1:0]    write_reg_m_q,  write_reg_m_d;

    // MEM/WB
    logic                 reg_write_w_q,  reg_write_w_d;
    logic                 mem_to_reg_w_q, mem_to_reg_w_d;
    logic [REG_AW-1:0]    write_reg_w_q,  write_reg_w_d;

    // hazard terms
    logic stall;
    logic match_rs_e, match_rt_e, match_rs_m, match_rt_m;

    // Decode op/funct into the ID control bundle; unknown ops decode as a bubble
    always_comb begin
        dec_valid      = 1'b0;
        dec_reg_write  = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_ctrl   = '0;
        use_rs         = 1'b0;
        use_rt         = 1'b0;
        Branch_D       = 2'b00;
        Jump_D         = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_valid   = 1'b1;
                dec_reg_dst = 1'b1;
                use_rs      = 1'b1;
                use_rt      = 1'b1;
                case (funct)
                    F_ADD: begin dec_reg_write = 1'b1; dec_alu_ctrl = ALU_ADD; end
                    F_SUB: begin dec_reg_write = 1'b1; dec_alu_ctrl = ALU_SUB; end
                    F_AND: begin dec_reg_write = 1'b1; dec_alu_ctrl = ALU_AND; end
                    F_OR:  begin dec_reg_write = 1'b1; dec_alu_ctrl = ALU_OR;  end
                    F_SLT: begin dec_reg_write = 1'b1; dec_alu_ctrl = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_LW: begin
                dec_valid      = 1'b1;
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_ctrl   = ALU_ADD;
                use_rs         = 1'b1;
            end
            OP_SW: begin
                dec_valid     = 1'b1;
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctrl  = ALU_ADD;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            OP_BEQ: begin
                dec_valid    = 1'b1;
                Branch_D     = 2'b01;
                dec_alu_ctrl = ALU_SUB;
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            OP_BNE: begin
                dec_valid    = 1'b1;
                Branch_D     = 2'b10;
                dec_alu_ctrl = ALU_SUB;
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            OP_ADDI: begin
                dec_valid     = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctrl  = ALU_ADD;
                use_rs        = 1'b1;
            end
            OP_J: begin
                dec_valid = 1'b1;
                Jump_D    = 1'b1;
            end
            default: ;
        endcase
        // an unrecognised op carries no destination so it is a clean bubble
        dec_write_reg = dec_reg_dst ? rd_D : (dec_valid ? rt_D : '0);
    end

    // Compare used ID sources (never $0) against the E and M destinations
    always_comb begin
        match_rs_e = use_rs && (rs_D != '0) && (rs_D == write_reg_e_q);
        match_rt_e = use_rt && (rt_D != '0) && (rt_D == write_reg_e_q);
        match_rs_m = use_rs && (rs_D != '0) && (rs_D == write_reg_m_q);
        match_rt_m = use_rt && (rt_D != '0) && (rt_D == write_reg_m_q);
`ifdef FORWARD_EN
        stall = (mem_to_reg_e_q && (match_rs_e || match_rt_e))
             || ((Branch_D != 2'b00)
                 && ((reg_write_e_q && (match_rs_e || match_rt_e))
                  || (mem_to_reg_m_q && (match_rs_m || match_rt_m))));
`else
        stall = (reg_write_e_q && (match_rs_e || match_rt_e))
             || (reg_write_m_q && (match_rs_m || match_rt_m));
`endif
    end

`ifdef FORWARD_EN
    // Select forwarding sources for the EX operands; M wins over W
    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        if (reg_write_m_q && (rs_e_q != '0) && (rs_e_q == write_reg_m_q))
            ForwardA_E = 2'b10;
        else if (reg_write_w_q && (rs_e_q != '0) && (rs_e_q == write_reg_w_q))
            ForwardA_E = 2'b01;
        if (reg_write_m_q && (rt_e_q != '0) && (rt_e_q == write_reg_m_q))
            ForwardB_E = 2'b10;
        else if (reg_write_w_q && (rt_e_q != '0) && (rt_e_q == write_reg_w_q))
            ForwardB_E = 2'b01;
    end
`endif

    // Next-state of every pipeline register; a stall loads a bubble into ID/EX
    always_comb begin
        reg_write_e_d  = stall ? 1'b0 : dec_reg_write;
        mem_to_reg_e_d = stall ? 1'b0 : dec_mem_to_reg;
        mem_write_e_d  = stall ? 1'b0 : dec_mem_write;
        alu_src_e_d    = stall ? 1'b0 : dec_alu_src;
        alu_ctrl_e_d   = stall ? '0   : dec_alu_ctrl;
        write_reg_e_d  = stall ? '0   : dec_write_reg;
`ifdef FORWARD_EN
        rs_e_d         = stall ? '0   : rs_D;
        rt_e_d         = stall ? '0   : rt_D;
`endif
        reg_write_m_d  = reg_write_e_q;
        mem_to_reg_m_d = mem_to_reg_e_q;
        mem_write_m_d  = mem_write_e_q;
        write_reg_m_d  = write_reg_e_q;
        reg_write_w_d  = reg_write_m_q;
        mem_to_reg_w_d = mem_to_reg_m_q;
        write_reg_w_d  = write_reg_m_q;
    end

    // Pipeline registers; reset turns every stage into a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_e_q  <= 1'b0;
            mem_to_reg_e_q <= 1'b0;
            mem_write_e_q  <= 1'b0;
            alu_src_e_q    <= 1'b0;
            alu_ctrl_e_q   <= '0;
            write_reg_e_q  <= '0;
`ifdef FORWARD_EN
            rs_e_q         <= '0;
            rt_e_q         <= '0;
`endif
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            write_reg_m_q  <= '0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            write_reg_w_q  <= '0;
        end else begin
            reg_write_e_q  <= reg_write_e_d;
            mem_to_reg_e_q <= mem_to_reg_e_d;
            mem_write_e_q  <= mem_write_e_d;
            alu_src_e_q    <= alu_src_e_d;
            alu_ctrl_e_q   <= alu_ctrl_e_d;
            write_reg_e_q  <= write_reg_e_d;
`ifdef FORWARD_EN
            rs_e_q         <= rs_e_d;
            rt_e_q         <= rt_e_d;
`endif
            reg_write_m_q  <= reg_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            mem_write_m_q  <= mem_write_m_d;
            write_reg_m_q  <= write_reg_m_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            write_reg_w_q  <= write_reg_w_d;
        end
    end

    assign AluControl_E = alu_ctrl_e_q;
    assign AluSrc_E     = alu_src_e_q;
    assign WriteReg_E   = write_reg_e_q;
    assign MemWrite_M   = mem_write_m_q;
    assign RegWrite_M   = reg_write_m_q;
    assign MemtoReg_M   = mem_to_reg_m_q;
    assign WriteReg_M   = write_reg_m_q;
    assign RegWrite_W   = reg_write_w_q;
    assign MemtoReg_W   = mem_to_reg_w_q;
    assign WriteReg_W   = write_reg_w_q;
    assign StallF       = stall;
    assign StallD       = stall;
    assign FlushE       = stall;

endmodule
